nios_video_pll_lock_monitor: RTL and testbench
==============================================

NIOS_VIDEO_PLL_LOCK_MONITOR -- requirements
Module: nios_video_pll_lock_monitor

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per reset attempt (>=1).
REQ-002 Parameter LOCK_TIMEOUT, default 1000000: cycles to wait for lock before retrying (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 4096: cycles lock must stay continuously high before video release (>=1).
REQ-004 clk  input  1  single clock for all logic; reset is synchronous and active-high.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 pll_locked  input  1  PLL locked indication, asynchronous to clk.
REQ-007 force_relock  input  1  single-cycle request to restart the PLL.
REQ-008 clear_status  input  1  single-cycle clear of status counters and sticky flag.
REQ-009 pll_rst  output  1  reset to the video PLL.
REQ-010 video_reset  output  1  reset for pixel-domain logic; low only while lock is stable.
REQ-011 ready  output  1  high exactly when video_reset is low.
REQ-012 lock_lost  output  1  sticky flag: lock dropped while running.
REQ-013 lost_count  output  8  lock-loss events in RUN, saturating at 255.
REQ-014 retry_count  output  8  lock timeouts, saturating at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; locked_sync is high after the 2nd rising edge following the first edge sampling pll_locked high.
REQ-016 FSM states: PLLRST, WAIT_LOCK, SETTLE, RUN; one shared cycle counter, cleared on every state change.
REQ-017 PLLRST: pll_rst=1; after RST_CYCLES cycles in state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_sync=1 -> SETTLE; else counter reaching LOCK_TIMEOUT-1 -> PLLRST and retry_count increments.
REQ-019 SETTLE: locked_sync=0 -> WAIT_LOCK (no counter increment); else counter reaching SETTLE_CYCLES-1 -> RUN.
REQ-020 RUN: locked_sync=0 -> PLLRST, lost_count increments, lock_lost set.
REQ-021 force_relock in WAIT_LOCK, SETTLE or RUN -> PLLRST next edge, no status change; ignored in PLLRST (attempt not restarted).
REQ-022 force_relock and lock loss in the same RUN cycle: lock loss is counted.
REQ-023 Outputs pll_rst, video_reset, ready SHALL be Moore decodes of the state register: video_reset=1 and ready=0 in every state except RUN.
REQ-024 Counters SHALL saturate at 255, never wrap.
REQ-025 clear_status zeroes lost_count, retry_count, lock_lost; an increment/set event in the same cycle wins, leaving value 1 / flag set.
REQ-026 Minimum latency pll_locked rise (already in WAIT_LOCK) to ready rise: 2+1+SETTLE_CYCLES edges; ready SHALL fall one edge after locked_sync falls.

Reset
REQ-027 reset SHALL set state PLLRST, counter 0, synchronizer flops 0, pll_rst=1, video_reset=1, ready=0, lock_lost=0, lost_count=0, retry_count=0.
REQ-028 reset asserted mid-operation (any state) SHALL take effect on the next edge and restart the full sequence; status is lost.

Structure
REQ-029 Shared package nios_video_pll_pkg SHALL hold the state enumeration and default parameter constants.
REQ-030 Synchronizer SHALL be sub-module nios_video_pll_lock_sync (2-stage, reset to 0); all other logic in one always block set per concern.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8)
REQ-031 Reset release, pll_locked high from edge 10 -> pll_rst high edges 0-3, WAIT_LOCK from edge 4, ready rises after edge 21, counters 0.
REQ-032 pll_locked held low -> pll_rst re-pulses every 24 cycles; retry_count 1,2,3...; saturates at 255 after 255 timeouts.
REQ-033 In RUN, pll_locked low 1 cycle -> ready falls, pll_rst 4 cycles, lost_count=1, lock_lost=1; relock re-releases after 11 edges.
REQ-034 In SETTLE, pll_locked glitches low at counter 5 -> back to WAIT_LOCK, no counter change, settle restarts from 0.
REQ-035 clear_status coincident with RUN lock loss -> lost_count=1, lock_lost=1, retry_count=0.
REQ-036 force_relock in RUN and in PLLRST -> PLLRST next edge, counters unchanged; PLLRST duration unchanged (4).

Source files
------------

// File: rtl/nios_video_pll_pkg.sv
// Shared types and defaults for the video PLL lock monitor.
// Combinational helpers only; no clocked logic here.
package nios_video_pll_pkg;

  typedef enum logic [1:0] {
    ST_PLLRST    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 1000000;
  localparam int unsigned DEF_SETTLE_CYCLES = 4096;
  localparam int unsigned CNT_W             = 32;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/nios_video_pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock flag; 2 cycles latency.
// No flow control; reset clears both stages.
module nios_video_pll_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/nios_video_pll_lock_monitor.sv
// Sequences video PLL reset, waits for lock, releases pixel reset once lock is stable.
// Outputs are Moore decodes of the state; status counters saturate at 255.
module nios_video_pll_lock_monitor
  import nios_video_pll_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       force_relock,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       video_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lost_count,
  output logic [7:0] retry_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lost_q, lost_d;
  logic [7:0]       retry_q, retry_d;
  logic             lock_lost_q, lock_lost_d;
  logic             locked_sync;
  logic             timeout_evt;
  logic             loss_evt;

  nios_video_pll_lock_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(pll_locked),
    .sync_o (locked_sync)
  );

  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        // force_relock is deliberately ignored here so the pulse width stays fixed
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        timeout_evt = !locked_sync && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
        if (force_relock || timeout_evt) state_d = ST_PLLRST;
        else if (locked_sync)            state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (force_relock)                                  state_d = ST_PLLRST;
        else if (!locked_sync)                             state_d = ST_WAIT_LOCK;
        else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1))       state_d = ST_RUN;
      end
      ST_RUN: begin
        loss_evt = !locked_sync;
        if (loss_evt || force_relock) state_d = ST_PLLRST;
      end
      default: state_d = ST_PLLRST;
    endcase
  end

  // Counter is frozen in RUN since nothing times out there.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q)   cnt_d = '0;
    else if (state_q == ST_RUN) cnt_d = cnt_q;
  end

  always_comb begin
    lost_d      = lost_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    if (clear_status) begin
      lost_d      = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end
    if (loss_evt) begin
      lost_d      = clear_status ? 8'd1 : sat_inc(lost_q);
      lock_lost_d = 1'b1;
    end
    if (timeout_evt) retry_d = clear_status ? 8'd1 : sat_inc(retry_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= '0;
      lost_q      <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lost_q      <= lost_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst     = (state_q == ST_PLLRST);
  assign video_reset = (state_q != ST_RUN);
  assign ready       = (state_q == ST_RUN);
  assign lock_lost   = lock_lost_q;
  assign lost_count  = lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_nios_video_pll_lock_monitor.sv
// Directed bench for the PLL lock monitor with short timing parameters.
// Table rows drive inputs for n edges, then check outputs on the falling edge.
module tb_nios_video_pll_lock_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       clear_status = 1'b0;
  logic       pll_rst;
  logic       video_reset;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lost_count;
  logic [7:0] retry_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_video_pll_lock_monitor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .SETTLE_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .force_relock(force_relock),
    .clear_status(clear_status),
    .pll_rst     (pll_rst),
    .video_reset (video_reset),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .lost_count  (lost_count),
    .retry_count (retry_count)
  );

  typedef struct {
    logic       rst;
    logic       lck;
    logic       frc;
    logic       clr;
    int         n;
    logic       e_pll_rst;
    logic       e_ready;
    logic [7:0] e_lost;
    logic [7:0] e_retry;
    logic       e_ll;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic lck, input logic frc, input logic clr,
                     input int n, input logic e_pr, input logic e_rdy,
                     input logic [7:0] e_lost, input logic [7:0] e_retry, input logic e_ll);
    vec_t v;
    v.rst = rst; v.lck = lck; v.frc = frc; v.clr = clr; v.n = n;
    v.e_pll_rst = e_pr; v.e_ready = e_rdy; v.e_lost = e_lost;
    v.e_retry = e_retry; v.e_ll = e_ll;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rst, input logic lck, input logic frc, input logic clr);
    reset = rst; pll_locked = lck; force_relock = frc; clear_status = clr;
  endtask

  initial begin
    //  rst lck frc clr  n  pr rdy lost retry ll
    add(1, 0, 0, 0, 2, 1, 0, 0, 0, 0);  // reset state
    add(0, 0, 0, 0, 3, 1, 0, 0, 0, 0);  // PLLRST cnt 3
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // WAIT_LOCK
    add(0, 1, 0, 0, 2, 0, 0, 0, 0, 0);  // synchronizer filling
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);  // SETTLE
    add(0, 1, 0, 0, 7, 0, 0, 0, 0, 0);  // SETTLE cnt 7
    add(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);  // RUN: 11 edges after lock rise
    add(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);  // 1-cycle glitch, first stage
    add(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);  // locked_sync now low, still RUN
    add(0, 1, 0, 0, 1, 1, 0, 1, 0, 1);  // loss counted
    add(0, 1, 0, 0, 3, 1, 0, 1, 0, 1);
    add(0, 1, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 8, 0, 1, 1, 0, 1);  // re-released
    add(0, 1, 0, 1, 1, 0, 1, 0, 0, 0);  // plain clear
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);  // force in RUN
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);  // force in PLLRST ignored
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);  // PLLRST still 4 cycles
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 2, 0, 1, 0, 0, 0);  // locked_sync falls
    add(0, 0, 0, 1, 1, 1, 0, 1, 0, 1);  // clear + loss same cycle
    add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // reset mid-operation

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].lck, tbl[i].frc, tbl[i].clr);
      step(tbl[i].n);
      check($sformatf("row%0d.pll_rst", i), 32'(pll_rst), 32'(tbl[i].e_pll_rst));
      check($sformatf("row%0d.ready", i), 32'(ready), 32'(tbl[i].e_ready));
      check($sformatf("row%0d.video_reset", i), 32'(video_reset), 32'(!tbl[i].e_ready));
      check($sformatf("row%0d.lost_count", i), 32'(lost_count), 32'(tbl[i].e_lost));
      check($sformatf("row%0d.retry_count", i), 32'(retry_count), 32'(tbl[i].e_retry));
      check($sformatf("row%0d.lock_lost", i), 32'(lock_lost), 32'(tbl[i].e_ll));
    end

    // Lock never arrives: 24-cycle retry period, retry_count saturates at 255.
    drive(1, 0, 0, 0);
    step(1);
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 257; i++) begin
      step(23);
      check($sformatf("timeout%0d.pll_rst_low", i), 32'(pll_rst), 32'd0);
      step(1);
      check($sformatf("timeout%0d.pll_rst_high", i), 32'(pll_rst), 32'd1);
      check($sformatf("timeout%0d.retry_count", i), 32'(retry_count), (i > 255) ? 32'd255 : 32'(i));
    end
    check("timeout.lost_count", 32'(lost_count), 32'd0);

    // Glitch seen by the FSM at SETTLE counter 5: back to WAIT_LOCK, settle restarts.
    drive(1, 1, 0, 0);
    step(1);
    drive(0, 1, 0, 0);
    step(5);
    check("settle.entry_ready", 32'(ready), 32'd0);
    step(3);
    drive(0, 0, 0, 0);
    step(1);
    drive(0, 1, 0, 0);
    step(2);
    check("settle.back_wait_pll_rst", 32'(pll_rst), 32'd0);
    step(8);
    check("settle.restart_not_early", 32'(ready), 32'd0);
    step(1);
    check("settle.restart_ready", 32'(ready), 32'd1);
    check("settle.retry_count", 32'(retry_count), 32'd0);
    check("settle.lost_count", 32'(lost_count), 32'd0);
    check("settle.lock_lost", 32'(lock_lost), 32'd0);

    // Reset while in RUN restarts the full sequence.
    drive(1, 1, 0, 0);
    step(1);
    check("rst_run.ready", 32'(ready), 32'd0);
    check("rst_run.pll_rst", 32'(pll_rst), 32'd1);
    drive(0, 1, 0, 0);
    step(3);
    check("rst_run.pll_rst_held", 32'(pll_rst), 32'd1);
    step(1);
    check("rst_run.pll_rst_done", 32'(pll_rst), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
